// File: rtl/barrel_pkg.sv
// Shared types for the pipelined barrel shifter: shift modes, per-stage control
// payload and the legal-width rule.
package barrel_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_t;

  // Control that travels alongside the partial result through every stage.
  typedef struct packed {
    logic  valid;
    mode_t mode;
  } stage_t;

  localparam int MIN_WIDTH = 8;
  localparam int MAX_WIDTH = 64;

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditional shift by DIST (a power of two) plus its
// pipeline register with hold enable. Macro BARREL_ROTATE_EN enables the ROL wrap.
module shift_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1,
  localparam int SHW  = $clog2(WIDTH),
  localparam int SEL  = $clog2(DIST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  stage_t           d_ctrl,
  input  logic [WIDTH-1:0] d_data,
  input  logic [SHW-1:0]   d_shamt,
  output stage_t           q_ctrl,
  output logic [WIDTH-1:0] q_data,
  output logic [SHW-1:0]   q_shamt,
  output logic             q_zero
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] result;

  // Earlier SRA stages replicate the sign, so the partial MSB is still the original sign.
  always_comb begin
    shifted = {d_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
    case (d_ctrl.mode)
      MODE_SRL: shifted = {{DIST{1'b0}}, d_data[WIDTH-1:DIST]};
      MODE_SRA: shifted = {{DIST{d_data[WIDTH-1]}}, d_data[WIDTH-1:DIST]};
`ifdef BARREL_ROTATE_EN
      MODE_ROL: shifted = {d_data[WIDTH-DIST-1:0], d_data[WIDTH-1:WIDTH-DIST]};
`endif
      default:  shifted = {d_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
    endcase
  end

  assign result = d_shamt[SEL] ? shifted : d_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ctrl.valid <= 1'b0;
      q_ctrl.mode  <= MODE_SLL;
      q_data       <= '0;
      q_shamt      <= '0;
      q_zero       <= 1'b1;
    end else if (en) begin
      q_ctrl  <= d_ctrl;
      q_data  <= result;
      q_shamt <= d_shamt;
      q_zero  <= (result == '0);
    end
  end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: SHW stages, stage k shifts by 2^k, whole-pipe stall on
// output backpressure. Macro BARREL_ROTATE_EN makes mode 11 a rotate instead of SLL.
module pipe_barrel_shifter
  import barrel_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("pipe_barrel_shifter: WIDTH must be a power of two between 8 and 64");
  end

  // Index 0 is the input beat; index gi+1 is the register of stage gi.
  stage_t           ctrl_s  [SHW+1];
  logic [WIDTH-1:0] data_s  [SHW+1];
  logic [SHW-1:0]   shamt_s [SHW+1];
  logic             zero_s  [SHW];
  logic             advance;

  // Every stage moves together, so a bubble never blocks progress unless the head stalls.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign ctrl_s[0].valid = in_valid;
  assign ctrl_s[0].mode  = mode_t'(in_mode);
  assign data_s[0]       = in_data;
  assign shamt_s[0]      = in_shamt;

  for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << gi)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (advance),
      .d_ctrl  (ctrl_s[gi]),
      .d_data  (data_s[gi]),
      .d_shamt (shamt_s[gi]),
      .q_ctrl  (ctrl_s[gi+1]),
      .q_data  (data_s[gi+1]),
      .q_shamt (shamt_s[gi+1]),
      .q_zero  (zero_s[gi])
    );
  end

  assign out_valid = ctrl_s[SHW].valid;
  assign out_data  = data_s[SHW];
  assign out_zero  = zero_s[SHW-1];

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter at WIDTH 16, 32 and 64 against an
// arithmetic reference model; honours BARREL_ROTATE_EN for mode 11.
`timescale 1ns/1ps
module tb_pipe_barrel_shifter;

  localparam int NDUT = 3;
`ifdef BARREL_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [NDUT];
  logic [63:0] in_data   [NDUT];
  logic [5:0]  in_shamt  [NDUT];
  logic [1:0]  in_mode   [NDUT];
  logic        out_ready [NDUT];
  logic        in_ready  [NDUT];
  logic        out_valid [NDUT];
  logic        out_zero  [NDUT];
  logic [63:0] out_data  [NDUT];
  logic [15:0] od16;
  logic [31:0] od32;

  int checks = 0;
  int passed = 0;

  assign out_data[0] = {48'd0, od16};
  assign out_data[1] = {32'd0, od32};

  always #5 clk = ~clk;

  pipe_barrel_shifter #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][15:0]), .in_shamt(in_shamt[0][3:0]), .in_mode(in_mode[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od16), .out_zero(out_zero[0])
  );

  pipe_barrel_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][31:0]), .in_shamt(in_shamt[1][4:0]), .in_mode(in_mode[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od32), .out_zero(out_zero[1])
  );

  pipe_barrel_shifter #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_shamt(in_shamt[2]), .in_mode(in_mode[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .out_zero(out_zero[2])
  );

  function automatic logic [63:0] mask_of(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: plain shifts on a w-bit value held in 64 bits.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int sh,
                                            input logic [1:0] m, input int w);
    logic [63:0] mask, x, r;
    mask = mask_of(w);
    x = d & mask;
    case (m)
      2'b01: r = x >> sh;
      2'b10: begin
        r = x >> sh;
        if (x[w-1]) r = r | (mask & ~(mask >> sh));
      end
      2'b11: r = ROT_EN ? ((x << sh) | (x >> (w - sh))) : (x << sh);
      default: r = x << sh;
    endcase
    return r & mask;
  endfunction

  task automatic idle_all();
    for (int k = 0; k < NDUT; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = 64'd0;
      in_shamt[k]  = 6'd0;
      in_mode[k]   = 2'b00;
      out_ready[k] = 1'b1;
    end
  endtask

  task automatic send_one(input logic [63:0] d, input int sh, input logic [1:0] m,
                          output logic [63:0] got, output logic gz, output int lat);
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = d; in_shamt[0] = sh[5:0]; in_mode[0] = m;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    lat = 1;
    while (!out_valid[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = out_data[0];
    gz  = out_zero[0];
    if (!out_valid[0]) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (out_valid[k] !== 1'b0) $display("FAIL reset_valid dut%0d: got %b want 0", k, out_valid[k]);
      else passed++;
      checks++;
      if (out_data[k] !== 64'd0) $display("FAIL reset_data dut%0d: got %h want 0", k, out_data[k]);
      else passed++;
      checks++;
      if (out_zero[k] !== 1'b1) $display("FAIL reset_zero dut%0d: got %b want 1", k, out_zero[k]);
      else passed++;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1) $display("FAIL reset_ready dut%0d: got %b want 1", k, in_ready[k]);
      else passed++;
    end
  endtask

  task automatic test_sll_latency();
    logic [63:0] got;
    logic gz;
    int lat;
    send_one(64'h00FF, 8, 2'b00, got, gz, lat);
    checks++;
    if (lat !== 4) $display("FAIL sll_latency: got %0d cycles want 4", lat);
    else passed++;
    checks++;
    if (got !== 64'hFF00) $display("FAIL sll_data: got %h want ff00", got);
    else passed++;
    checks++;
    if (gz !== 1'b0) $display("FAIL sll_zero: got %b want 0", gz);
    else passed++;
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b0) $display("FAIL sll_no_dup: out_valid %b want 0", out_valid[0]);
    else passed++;
  endtask

  task automatic test_sra_srl_rol();
    logic [63:0] got;
    logic gz;
    int lat;
    send_one(64'h8000, 15, 2'b10, got, gz, lat);
    checks++;
    if (got !== 64'hFFFF) $display("FAIL sra_fill: got %h want ffff", got);
    else passed++;
    send_one(64'h8000, 15, 2'b01, got, gz, lat);
    checks++;
    if (got !== 64'h0001) $display("FAIL srl_fill: got %h want 0001", got);
    else passed++;
    send_one(64'h8001, 1, 2'b11, got, gz, lat);
    checks++;
    if (got !== (ROT_EN ? 64'h0003 : 64'h0002))
      $display("FAIL mode11: got %h want %h", got, ROT_EN ? 64'h0003 : 64'h0002);
    else passed++;
    for (int m = 0; m < 4; m++) begin
      send_one(64'hA5C3, 0, m[1:0], got, gz, lat);
      checks++;
      if (got !== 64'hA5C3) $display("FAIL shamt0 mode%0d: got %h want a5c3", m, got);
      else passed++;
    end
  endtask

  task automatic test_stream();
    logic [63:0] want;
    for (int cyc = 0; cyc < 22; cyc++) begin
      @(negedge clk);
      out_ready[0] = 1'b1;
      in_valid[0]  = (cyc < 16);
      in_data[0]   = 64'h0001;
      in_shamt[0]  = 6'(cyc);
      in_mode[0]   = 2'b00;
      #1;
      if (cyc >= 4 && cyc < 20) begin
        want = 64'h0001 << (cyc - 4);
        checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== want)
          $display("FAIL stream beat %0d: valid %b data %h want 1 %h", cyc - 4, out_valid[0], out_data[0], want);
        else passed++;
      end else if (cyc == 21) begin
        checks++;
        if (out_valid[0] !== 1'b0) $display("FAIL stream_end: out_valid %b want 0", out_valid[0]);
        else passed++;
      end
    end
    idle_all();
  endtask

  task automatic test_backpressure();
    localparam int N = 14;
    logic [63:0] bd [N];
    int          bs [N];
    logic [1:0]  bm [N];
    logic [63:0] q [$];
    int sent = 0, recv = 0;
    bit saw_stall = 0, zero_seen = 0;
    for (int i = 0; i < N; i++) begin
      bd[i] = 64'($urandom_range(1, 16'hFFFF));
      bs[i] = $urandom_range(0, 15);
      bm[i] = 2'($urandom_range(0, 3));
    end
    bd[5] = 64'hF000; bs[5] = 4; bm[5] = 2'b00;
    for (int cyc = 0; cyc < 80 && recv < N; cyc++) begin
      @(negedge clk);
      out_ready[0] = !(cyc >= 8 && cyc < 14);
      in_valid[0]  = (sent < N);
      if (sent < N) begin
        in_data[0] = bd[sent]; in_shamt[0] = 6'(bs[sent]); in_mode[0] = bm[sent];
      end
      #1;
      if (!in_ready[0]) saw_stall = 1;
      if (out_valid[0]) begin
        checks++;
        if (q.size() == 0) $display("FAIL bp_extra: unexpected beat %h", out_data[0]);
        else if (out_data[0] !== q[0] || out_zero[0] !== (q[0] == 64'd0))
          $display("FAIL bp_data: got %h/%b want %h/%b", out_data[0], out_zero[0], q[0], q[0] == 64'd0);
        else passed++;
        if (out_ready[0] && q.size() != 0) begin
          if (q[0] == 64'd0 && out_zero[0] === 1'b1) zero_seen = 1;
          void'(q.pop_front());
          recv++;
        end
      end
      if (in_valid[0] && in_ready[0]) begin
        q.push_back(ref_shift(bd[sent], bs[sent], bm[sent], 16));
        sent++;
      end
    end
    checks++;
    if (!saw_stall) $display("FAIL bp_in_ready: in_ready never low, want a stall");
    else passed++;
    checks++;
    if (recv != N || q.size() != 0) $display("FAIL bp_count: got %0d beats want %0d", recv, N);
    else passed++;
    checks++;
    if (!zero_seen) $display("FAIL bp_zero: out_zero 0 for f000<<4, want 1");
    else passed++;
    idle_all();
  endtask

  task automatic test_reset_midflight();
    bit stale = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      out_ready[0] = 1'b0;
      in_valid[0]  = (cyc < 3);
      in_data[0]   = 64'h0100 + 64'(cyc);
      in_shamt[0]  = 6'(cyc);
      in_mode[0]   = 2'b00;
    end
    #1;
    checks++;
    if (out_valid[0] !== 1'b1) $display("FAIL midrst_pre: out_valid %b want 1", out_valid[0]);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || out_data[0] !== 64'd0 || out_zero[0] !== 1'b1)
      $display("FAIL midrst_clear: valid %b data %h zero %b want 0 0 1", out_valid[0], out_data[0], out_zero[0]);
    else passed++;
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) stale = 1;
    end
    checks++;
    if (stale) $display("FAIL midrst_stale: beat emerged after reset, want none");
    else passed++;
  endtask

  task automatic test_random(input int ncyc, input int reset_at);
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [63:0] q2 [$];
    logic [63:0] front;
    bit have;
    int w;
    for (int cyc = 0; cyc < ncyc + 12; cyc++) begin
      @(negedge clk);
      if (cyc == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
          checks++;
          if (out_valid[k] !== 1'b0) $display("FAIL rnd_reset w=%0d: out_valid %b want 0", 16 << k, out_valid[k]);
          else passed++;
        end
        q0.delete(); q1.delete(); q2.delete();
        @(negedge clk);
        rst_n = 1'b1;
      end
      for (int k = 0; k < NDUT; k++) begin
        w = 16 << k;
        if (cyc < ncyc) begin
          in_valid[k]  = ($urandom_range(0, 3) != 0);
          in_data[k]   = {$urandom, $urandom} & mask_of(w);
          in_shamt[k]  = 6'($urandom_range(0, w - 1));
          in_mode[k]   = 2'($urandom_range(0, 3));
          out_ready[k] = ($urandom_range(0, 2) != 0);
        end else begin
          in_valid[k]  = 1'b0;
          out_ready[k] = 1'b1;
        end
      end
      #1;
      for (int k = 0; k < NDUT; k++) begin
        w = 16 << k;
        have = 0;
        front = 64'd0;
        case (k)
          0: begin have = (q0.size() != 0); if (have) front = q0[0]; end
          1: begin have = (q1.size() != 0); if (have) front = q1[0]; end
          default: begin have = (q2.size() != 0); if (have) front = q2[0]; end
        endcase
        if (out_valid[k]) begin
          checks++;
          if (!have) $display("FAIL rnd_extra w=%0d: unexpected beat %h", w, out_data[k]);
          else if (out_data[k] !== front || out_zero[k] !== (front == 64'd0))
            $display("FAIL rnd_data w=%0d: got %h/%b want %h/%b", w, out_data[k], out_zero[k], front, front == 64'd0);
          else passed++;
          if (out_ready[k] && have) begin
            case (k)
              0: void'(q0.pop_front());
              1: void'(q1.pop_front());
              default: void'(q2.pop_front());
            endcase
          end
        end
        if (in_valid[k] && in_ready[k]) begin
          front = ref_shift(in_data[k], int'(in_shamt[k]), in_mode[k], w);
          case (k)
            0: q0.push_back(front);
            1: q1.push_back(front);
            default: q2.push_back(front);
          endcase
        end
      end
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0)
      $display("FAIL rnd_lost: %0d/%0d/%0d beats missing, want 0/0/0", q0.size(), q1.size(), q2.size());
    else passed++;
    idle_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sll_latency();
    test_sra_srl_rol();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_random(400, 150);
    test_random(300, 1000);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
